// File: rtl/usbfs_tx_arb.sv
// usbfs_tx_arb: arbitrates between handshake and data packet requesters for a
// USB full-speed transmitter. It loads data payloads into the transmit buffer,
// presents the PID to the packet transmitter, and tracks per-endpoint DATA0/DATA1
// toggles, which only advance once the host ACKs the previous data packet.
module usbfs_tx_arb #(
  parameter int MAX_PKT = 8,
  parameter int N_EP = 2,
  localparam int EP_W = (N_EP > 1) ? $clog2(N_EP) : 1,
  localparam int IDX_W = $clog2(MAX_PKT),
  localparam int CNT_W = $clog2(MAX_PKT + 1)
) (
  input  logic             i_clk_12MHz,
  input  logic             i_rst,
  input  logic             i_hsReq,
  input  logic [3:0]       i_hsPid,
  output logic             o_hsGnt,
  input  logic             i_dataReq,
  input  logic [EP_W-1:0]  i_dataEp,
  input  logic             i_dataZlp,
  output logic             o_dataGnt,
  input  logic             i_byteValid,
  input  logic [7:0]       i_byte,
  input  logic             i_byteLast,
  output logic             o_byteReady,
  input  logic             i_hostAck,
  input  logic [N_EP-1:0]  i_toggleClr,
  output logic             o_awaitAck,
  output logic             o_txValid,
  input  logic             i_txReady,
  output logic [3:0]       o_txPid,
  input  logic             i_txEopDone,
  output logic             o_wrEn,
  output logic [IDX_W-1:0] o_wrIdx,
  output logic [7:0]       o_wrByte,
  output logic             o_busy
);

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_EOP} stateType;

  stateType         state, stateNext;
  logic [3:0]       pidReg, pidNext;
  logic [EP_W-1:0]  epReg, epNext;
  logic             isData, isDataNext;
  logic [CNT_W-1:0] count, countNext;
  logic             awaitAck;
  logic [N_EP-1:0]  toggle;
  logic             ackTaken;

  logic             hsGnt, dataGnt, byteReady, wrEn, txValid;
  logic [IDX_W-1:0] wrIdx;
  logic [7:0]       wrByte;

  // Next-state and output decode: grants only in IDLE, byte writes only in LOAD.
  always_comb begin
    stateNext  = state;
    pidNext    = pidReg;
    epNext     = epReg;
    isDataNext = isData;
    countNext  = count;
    hsGnt      = 1'b0;
    dataGnt    = 1'b0;
    byteReady  = 1'b0;
    wrEn       = 1'b0;
    wrIdx      = '0;
    wrByte     = '0;
    txValid    = 1'b0;
    case (state)
      IDLE: begin
        if (i_hsReq) begin
          hsGnt      = 1'b1;
          pidNext    = i_hsPid;
          isDataNext = 1'b0;
          stateNext  = SEND;
        end else if (i_dataReq) begin
          dataGnt    = 1'b1;
          epNext     = i_dataEp;
          isDataNext = 1'b1;
          countNext  = '0;
          pidNext    = toggle[i_dataEp] ? PID_DATA1 : PID_DATA0;
          stateNext  = i_dataZlp ? SEND : LOAD;
        end
      end
      LOAD: begin
        byteReady = 1'b1;
        if (i_byteValid) begin
          wrEn      = 1'b1;
          wrIdx     = count[IDX_W-1:0];
          wrByte    = i_byte;
          countNext = count + CNT_W'(1);
          if (i_byteLast || count == LAST_CNT) begin
            stateNext = SEND;
          end
        end
      end
      SEND: begin
        txValid = 1'b1;
        if (i_txReady) begin
          stateNext = WAIT_EOP;
        end
      end
      WAIT_EOP: begin
        if (i_txEopDone) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, latched PID/endpoint and byte counter registers.
  always_ff @(posedge i_clk_12MHz) begin
    if (i_rst) begin
      state  <= IDLE;
      pidReg <= '0;
      epReg  <= '0;
      isData <= 1'b0;
      count  <= '0;
    end else begin
      state  <= stateNext;
      pidReg <= pidNext;
      epReg  <= epNext;
      isData <= isDataNext;
      count  <= countNext;
    end
  end

  assign ackTaken = i_hostAck && awaitAck;

  // Pending-ACK flag: set when a data packet finishes, cleared by any grant or a host ACK.
  always_ff @(posedge i_clk_12MHz) begin
    if (i_rst) begin
      awaitAck <= 1'b0;
    end else if (hsGnt || dataGnt) begin
      awaitAck <= 1'b0;
    end else if (state == WAIT_EOP && i_txEopDone && isData) begin
      awaitAck <= 1'b1;
    end else if (ackTaken) begin
      awaitAck <= 1'b0;
    end
  end

  // Per-endpoint data toggles: an explicit clear beats an ACK-driven flip.
  always_ff @(posedge i_clk_12MHz) begin
    if (i_rst) begin
      toggle <= '0;
    end else begin
      for (int k = 0; k < N_EP; k++) begin
        if (i_toggleClr[k]) begin
          toggle[k] <= 1'b0;
        end else if (ackTaken && epReg == EP_W'(k)) begin
          toggle[k] <= ~toggle[k];
        end
      end
    end
  end

  // Outputs are forced quiet while reset is held, even in the first reset cycle.
  assign o_hsGnt     = hsGnt & ~i_rst;
  assign o_dataGnt   = dataGnt & ~i_rst;
  assign o_byteReady = byteReady & ~i_rst;
  assign o_wrEn      = wrEn & ~i_rst;
  assign o_wrIdx     = i_rst ? '0 : wrIdx;
  assign o_wrByte    = i_rst ? '0 : wrByte;
  assign o_txValid   = txValid & ~i_rst;
  assign o_txPid     = i_rst ? 4'b0000 : pidReg;
  assign o_awaitAck  = awaitAck & ~i_rst;
  assign o_busy      = (state != IDLE) & ~i_rst;

endmodule

// File: tb/tb_usbfs_tx_arb.sv
// tb_usbfs_tx_arb: drives handshake/data transactions into usbfs_tx_arb and
// checks grants, buffer writes, PIDs and toggle behaviour against a
// transaction-level model of the endpoint toggles.
module tb_usbfs_tx_arb;

  localparam int MAX_PKT = 8;
  localparam int N_EP = 2;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_hsReq = 1'b0;
  logic [3:0]      i_hsPid = '0;
  logic            o_hsGnt;
  logic            i_dataReq = 1'b0;
  logic [0:0]      i_dataEp = '0;
  logic            i_dataZlp = 1'b0;
  logic            o_dataGnt;
  logic            i_byteValid = 1'b0;
  logic [7:0]      i_byte = '0;
  logic            i_byteLast = 1'b0;
  logic            o_byteReady;
  logic            i_hostAck = 1'b0;
  logic [N_EP-1:0] i_toggleClr = '0;
  logic            o_awaitAck;
  logic            o_txValid;
  logic            i_txReady = 1'b0;
  logic [3:0]      o_txPid;
  logic            i_txEopDone = 1'b0;
  logic            o_wrEn;
  logic [2:0]      o_wrIdx;
  logic [7:0]      o_wrByte;
  logic            o_busy;

  // 12 MHz-style free-running clock.
  always #5 clk = ~clk;

  usbfs_tx_arb #(.MAX_PKT(MAX_PKT), .N_EP(N_EP)) dut (
    .i_clk_12MHz(clk),
    .i_rst(i_rst),
    .i_hsReq(i_hsReq),
    .i_hsPid(i_hsPid),
    .o_hsGnt(o_hsGnt),
    .i_dataReq(i_dataReq),
    .i_dataEp(i_dataEp),
    .i_dataZlp(i_dataZlp),
    .o_dataGnt(o_dataGnt),
    .i_byteValid(i_byteValid),
    .i_byte(i_byte),
    .i_byteLast(i_byteLast),
    .o_byteReady(o_byteReady),
    .i_hostAck(i_hostAck),
    .i_toggleClr(i_toggleClr),
    .o_awaitAck(o_awaitAck),
    .o_txValid(o_txValid),
    .i_txReady(i_txReady),
    .o_txPid(o_txPid),
    .i_txEopDone(i_txEopDone),
    .o_wrEn(o_wrEn),
    .o_wrIdx(o_wrIdx),
    .o_wrByte(o_wrByte),
    .o_busy(o_busy)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model: toggle per endpoint, pending-ACK flag and its endpoint.
  bit mToggle [N_EP];
  bit mAwait;
  int mEp;

  typedef struct {
    bit              isHs;
    logic [3:0]      hsPid;
    int              ep;
    int              nBytes;
    bit              zlp;
    bit              useLast;
    bit              ackAfter;
    logic [N_EP-1:0] clrAfter;
    logic [3:0]      expPid;
    int              expWrites;
  } vecT;

  vecT vecs [9];
  logic [3:0] hsPids [3];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge and drop all single-cycle pulses.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    i_txReady   = 1'b0;
    i_txEopDone = 1'b0;
    i_hostAck   = 1'b0;
    i_toggleClr = '0;
    i_byteValid = 1'b0;
    i_byteLast  = 1'b0;
    i_byte      = '0;
  endtask

  function automatic logic [3:0] modelPid(input int ep);
    return mToggle[ep] ? PID_DATA1 : PID_DATA0;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "HsGnt"}, o_hsGnt, 0);
    checkOutput({tag, "DataGnt"}, o_dataGnt, 0);
    checkOutput({tag, "ByteReady"}, o_byteReady, 0);
    checkOutput({tag, "Busy"}, o_busy, 0);
    checkOutput({tag, "TxValid"}, o_txValid, 0);
    checkOutput({tag, "AwaitAck"}, o_awaitAck, 0);
    checkOutput({tag, "WrEn"}, o_wrEn, 0);
    checkOutput({tag, "TxPid"}, o_txPid, 0);
    checkOutput({tag, "WrIdx"}, o_wrIdx, 0);
    checkOutput({tag, "WrByte"}, o_wrByte, 0);
  endtask

  // SEND for hold+1 cycles (txReady on the last), then WAIT_EOP, ending on the EOP-done cycle.
  task automatic sendPhase(input logic [3:0] expPid, input int hold);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) nextCycle();
      i_txReady = (h == hold);
      #2;
      checkOutput("sendTxValid", o_txValid, 1);
      checkOutput("sendTxPid", o_txPid, expPid);
      checkOutput("sendWrEn", o_wrEn, 0);
      checkOutput("sendBusy", o_busy, 1);
      checkOutput("sendNoGrant", {o_hsGnt, o_dataGnt}, 0);
    end
    nextCycle();
    #2;
    checkOutput("eopTxValid", o_txValid, 0);
    checkOutput("eopBusy", o_busy, 1);
    checkOutput("eopByteReady", o_byteReady, 0);
    checkOutput("eopNoGrant", {o_hsGnt, o_dataGnt}, 0);
    nextCycle();
    i_txEopDone = 1'b1;
    #2;
    checkOutput("eopDoneBusy", o_busy, 1);
  endtask

  task automatic sendHandshake(input logic [3:0] pid, input int hold);
    nextCycle();
    i_hsReq = 1'b1;
    i_hsPid = pid;
    #2;
    checkOutput("hsGnt", o_hsGnt, 1);
    checkOutput("hsDataGnt", o_dataGnt, 0);
    checkOutput("hsIdleBusy", o_busy, 0);
    checkOutput("hsAwaitBefore", o_awaitAck, mAwait);
    mAwait = 0;
    nextCycle();
    i_hsReq = 1'b0;
    i_hsPid = '0;
    sendPhase(pid, hold);
  endtask

  task automatic sendData(input int ep, input int n, input bit zlp, input bit useLast,
                          input bit rnd, input logic [3:0] expPid, input int expWrites);
    logic [7:0] b;
    int accepted;
    int writesSeen;
    bit ended;
    int hold;
    hold = rnd ? int'($urandom_range(0, 2)) : 1;
    nextCycle();
    i_dataReq = 1'b1;
    i_dataEp  = 1'(ep);
    i_dataZlp = zlp;
    #2;
    checkOutput("dataGnt", o_dataGnt, 1);
    checkOutput("dataHsGnt", o_hsGnt, 0);
    checkOutput("dataIdleBusy", o_busy, 0);
    checkOutput("dataAwaitBefore", o_awaitAck, mAwait);
    mAwait = 0;
    nextCycle();
    i_dataReq = 1'b0;
    i_dataZlp = 1'b0;
    if (zlp) begin
      sendPhase(expPid, hold);
    end else begin
      accepted = 0;
      writesSeen = 0;
      ended = 0;
      for (int i = 0; i < n; i++) begin
        if (i > 0) nextCycle();
        if (rnd && $urandom_range(0, 3) == 0) begin
          #2;
          checkOutput("gapByteReady", o_byteReady, !ended);
          checkOutput("gapWrEn", o_wrEn, 0);
          nextCycle();
        end
        b = rnd ? 8'($urandom) : 8'((i + 1) * 17);
        i_byteValid = 1'b1;
        i_byte      = b;
        i_byteLast  = useLast && (i == n - 1);
        #2;
        writesSeen += int'(o_wrEn);
        checkOutput("loadByteReady", o_byteReady, !ended);
        if (!ended) begin
          checkOutput("loadWrEn", o_wrEn, 1);
          checkOutput("loadWrIdx", o_wrIdx, accepted);
          checkOutput("loadWrByte", o_wrByte, b);
          checkOutput("loadTxValid", o_txValid, 0);
          accepted++;
          if (i_byteLast || accepted == MAX_PKT) ended = 1;
        end else begin
          checkOutput("truncWrEn", o_wrEn, 0);
          checkOutput("truncTxValid", o_txValid, 1);
        end
      end
      checkOutput("pktEnded", ended, 1);
      checkOutput("writeCount", writesSeen, expWrites);
      nextCycle();
      sendPhase(expPid, hold);
    end
    mAwait = 1;
    mEp = ep;
  endtask

  // One IDLE cycle carrying optional host ACK / toggle clear pulses.
  task automatic pulseCtrl(input bit ack, input logic [N_EP-1:0] clr);
    nextCycle();
    i_hostAck   = ack;
    i_toggleClr = clr;
    #2;
    checkOutput("idleBusy", o_busy, 0);
    checkOutput("idleAwait", o_awaitAck, mAwait);
    checkOutput("idleByteReady", o_byteReady, 0);
    checkOutput("idleTxValid", o_txValid, 0);
    if (ack && mAwait) begin
      mToggle[mEp] = !mToggle[mEp];
      mAwait = 0;
    end
    for (int k = 0; k < N_EP; k++) begin
      if (clr[k]) mToggle[k] = 0;
    end
  endtask

  task automatic applyStimulus(input vecT v, input bit rnd);
    if (v.isHs) sendHandshake(v.hsPid, rnd ? int'($urandom_range(0, 2)) : 1);
    else sendData(v.ep, v.nBytes, v.zlp, v.useLast, rnd, v.expPid, v.expWrites);
    pulseCtrl(v.ackAfter, v.clrAfter);
  endtask

  // Main sequence: reset, vector table, corner cases, then randomized traffic.
  initial begin
    vecT v;
    hsPids[0] = PID_ACK;
    hsPids[1] = PID_NAK;
    hsPids[2] = PID_STALL;
    //         isHs hsPid    ep n   zlp last ack clr    expPid     writes
    vecs[0] = '{1, PID_NAK,  0, 0,  0,  0,   0,  2'b00, PID_NAK,   0};
    vecs[1] = '{0, 4'b0000,  1, 3,  0,  1,   1,  2'b00, PID_DATA0, 3};
    vecs[2] = '{0, 4'b0000,  1, 3,  0,  1,   0,  2'b00, PID_DATA1, 3};
    vecs[3] = '{0, 4'b0000,  0, 2,  0,  1,   0,  2'b00, PID_DATA0, 2};
    vecs[4] = '{0, 4'b0000,  0, 2,  0,  1,   1,  2'b00, PID_DATA0, 2};
    vecs[5] = '{0, 4'b0000,  0, 1,  0,  1,   0,  2'b00, PID_DATA1, 1};
    vecs[6] = '{0, 4'b0000,  0, 10, 0,  0,   0,  2'b00, PID_DATA1, 8};
    vecs[7] = '{0, 4'b0000,  1, 0,  1,  1,   1,  2'b00, PID_DATA1, 0};
    vecs[8] = '{0, 4'b0000,  1, 1,  0,  1,   0,  2'b00, PID_DATA0, 1};

    for (int k = 0; k < N_EP; k++) mToggle[k] = 0;
    mAwait = 0;
    mEp = 0;

    $display("[TB] reset");
    i_hsReq = 1'b1;
    i_dataReq = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    checkAllZero("rst");
    nextCycle();
    i_rst = 1'b0;
    i_hsReq = 1'b0;
    i_dataReq = 1'b0;
    #2;
    checkAllZero("postRst");

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], 0);

    $display("[TB] toggle clear racing host ACK");
    pulseCtrl(1, 2'b10);
    sendData(1, 1, 0, 1, 0, PID_DATA0, 1);
    pulseCtrl(0, 2'b00);

    $display("[TB] simultaneous requests");
    nextCycle();
    i_hsReq = 1'b1;
    i_hsPid = PID_ACK;
    i_dataReq = 1'b1;
    i_dataEp = 1'b0;
    i_dataZlp = 1'b1;
    #2;
    checkOutput("simulHsGnt", o_hsGnt, 1);
    checkOutput("simulDataHeld", o_dataGnt, 0);
    mAwait = 0;
    nextCycle();
    i_hsReq = 1'b0;
    sendPhase(PID_ACK, 1);
    sendData(0, 0, 1, 1, 0, modelPid(0), 0);
    pulseCtrl(0, 2'b00);

    $display("[TB] reset during LOAD");
    nextCycle();
    i_dataReq = 1'b1;
    i_dataEp = 1'b0;
    #2;
    checkOutput("rstLoadGnt", o_dataGnt, 1);
    nextCycle();
    i_byteValid = 1'b1;
    i_byte = 8'hAA;
    #2;
    checkOutput("rstLoadWrEn", o_wrEn, 1);
    nextCycle();
    i_rst = 1'b1;
    i_byteValid = 1'b1;
    i_byte = 8'h55;
    #2;
    checkAllZero("midRst");
    nextCycle();
    i_rst = 1'b0;
    i_dataReq = 1'b0;
    #2;
    checkAllZero("afterMidRst");
    for (int k = 0; k < N_EP; k++) mToggle[k] = 0;
    mAwait = 0;
    sendData(0, 1, 0, 1, 0, PID_DATA0, 1);
    pulseCtrl(0, 2'b00);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 40; it++) begin
      v.isHs = ($urandom_range(0, 3) == 0);
      v.hsPid = hsPids[$urandom_range(0, 2)];
      v.ep = int'($urandom_range(0, N_EP - 1));
      v.zlp = ($urandom_range(0, 4) == 0);
      v.useLast = ($urandom_range(0, 3) != 0);
      v.nBytes = v.useLast ? int'($urandom_range(1, MAX_PKT + 2))
                           : int'($urandom_range(MAX_PKT, MAX_PKT + 2));
      v.ackAfter = 1'($urandom_range(0, 1));
      v.clrAfter = ($urandom_range(0, 3) == 0) ? N_EP'($urandom) : '0;
      v.expPid = v.isHs ? v.hsPid : modelPid(v.ep);
      v.expWrites = v.zlp ? 0 : ((v.nBytes < MAX_PKT) ? v.nBytes : MAX_PKT);
      applyStimulus(v, 1);
    end
    pulseCtrl(0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usbfs_tx_arb.md
USBFS_TX_ARB -- requirements
Module: usbfs_tx_arb

Interface
REQ-001 The block SHALL have parameter MAX_PKT, default 8, in {8,16,32,64}: max data payload bytes, equal to the transmitter's wMaxPacketSize.
REQ-002 The block SHALL have parameter N_EP, default 2, range 1..8: number of IN endpoints with a data toggle.
REQ-003 The block SHALL have one clock and reset only; reset SHALL be synchronous and active-high:
- i_clk_12MHz  in  1  clock
- i_rst  in  1  synchronous active-high reset
REQ-004 The handshake requester ports SHALL be:
- i_hsReq  in  1  handshake request (level)
- i_hsPid  in  4  ACK=4'b0010, NAK=4'b1010, STALL=4'b1110
- o_hsGnt  out  1  one-cycle grant pulse
REQ-005 The data requester ports SHALL be:
- i_dataReq  in  1  data packet request (level)
- i_dataEp  in  $clog2(N_EP) (min 1)  endpoint index
- i_dataZlp  in  1  zero-length packet
- o_dataGnt  out  1  one-cycle grant pulse
REQ-006 The data byte stream ports SHALL be:
- i_byteValid  in  1  byte valid
- i_byte  in  8  payload byte
- i_byteLast  in  1  final byte
- o_byteReady  out  1  byte ready
REQ-007 The toggle control ports SHALL be:
- i_hostAck  in  1  host ACK pulse for last data packet
- i_toggleClr  in  N_EP  force endpoint toggle to DATA0
- o_awaitAck  out  1  data packet sent, ACK pending
REQ-008 The packet transmitter ports SHALL be:
- o_txValid  out  1  transmit valid
- i_txReady  in  1  transmit ready
- o_txPid  out  4  PID
- i_txEopDone  in  1  EOP done
- o_wrEn  out  1  buffer write enable
- o_wrIdx  out  $clog2(MAX_PKT)  buffer write index
- o_wrByte  out  8  buffer write byte
- o_busy  out  1  state != IDLE

Function
REQ-009 The FSM SHALL have exactly four states: IDLE, LOAD, SEND, WAIT_EOP.
REQ-010 In IDLE, i_hsReq SHALL take priority over i_dataReq when both are asserted in the same cycle.
REQ-011 On an IDLE handshake grant, the block SHALL pulse o_hsGnt, latch i_hsPid and go to SEND, giving o_txValid=1 in the next cycle (1-cycle latency).
REQ-012 On an IDLE data grant, the block SHALL pulse o_dataGnt and latch i_dataEp; it SHALL latch PID DATA0=4'b0011 if toggle[ep]==0, otherwise DATA1=4'b1011; next state SHALL be SEND if i_dataZlp, else LOAD.
REQ-013 In LOAD, o_byteReady SHALL be 1.
REQ-014 In LOAD, each byteValid&&byteReady beat SHALL drive o_wrEn=1, o_wrIdx=count and o_wrByte=i_byte combinationally in the same cycle, then increment count (width $clog2(MAX_PKT+1)), starting from 0.
REQ-015 LOAD SHALL go to SEND after the beat with i_byteLast, or after the beat where count reaches MAX_PKT, in which case i_byteLast is ignored and the packet is truncated.
REQ-016 o_wrEn SHALL be 0 in every state other than LOAD.
REQ-017 In SEND, o_txValid SHALL be 1 and o_txPid SHALL be the latched PID, held stable until i_txReady.
REQ-018 On o_txValid&&i_txReady the block SHALL go to WAIT_EOP.
REQ-019 In WAIT_EOP, i_txEopDone SHALL return the FSM to IDLE; new grants SHALL be possible from the following cycle.
REQ-020 On i_txEopDone of a data packet, o_awaitAck SHALL be set and the endpoint index retained.
REQ-021 On a handshake grant, o_awaitAck SHALL be cleared.
REQ-022 On i_hostAck while o_awaitAck==1, toggle[retained ep] SHALL invert and o_awaitAck SHALL clear.
REQ-023 i_hostAck while o_awaitAck==0 SHALL be ignored.
REQ-024 i_toggleClr[k] SHALL clear toggle[k] in any state and SHALL win over a simultaneous i_hostAck to the same endpoint.
REQ-025 A new data grant SHALL clear o_awaitAck without toggling, so an unacknowledged packet is retried with the same PID.
REQ-026 Requests arriving outside IDLE SHALL be held by the requester; grants SHALL occur only in IDLE.
REQ-027 o_busy SHALL be 1 whenever the state is not IDLE.

Reset
REQ-028 While i_rst is asserted, the block SHALL go to IDLE with all toggles=0, count=0, and o_awaitAck, o_txValid, o_wrEn, o_hsGnt, o_dataGnt, o_byteReady and o_busy all 0.
REQ-029 o_txPid, o_wrIdx and o_wrByte SHALL be 0 during reset.
REQ-030 Reset mid-LOAD or mid-WAIT_EOP SHALL abandon the packet with no pending grant; the transmitter shares i_rst.

Verification
REQ-031 The bench SHALL cover handshake: i_hsReq with PID 4'b1010 in IDLE -> o_hsGnt next edge, then o_txValid=1 and o_txPid=4'b1010 until i_txReady, then IDLE after i_txEopDone.
REQ-032 The bench SHALL cover data toggle: ep1 sends 3 bytes (0x11,0x22,0x33 last) -> wrIdx 0,1,2 and PID 4'b0011; i_hostAck; resend -> PID 4'b1011.
REQ-033 The bench SHALL cover retry: ep0 data is sent with no i_hostAck, then ep0 is requested again -> PID unchanged (4'b0011).
REQ-034 The bench SHALL cover simultaneous requests: i_hsReq and i_dataReq in the same cycle -> handshake granted first, data granted in the first IDLE cycle after its EOP.
REQ-035 The bench SHALL cover truncation and ZLP: MAX_PKT=8 with 10 bytes offered and no last -> exactly 8 writes and o_byteReady=0 afterwards; a ZLP request -> no writes and o_txValid one cycle after the grant.
REQ-036 The bench SHALL cover toggle clear and reset: i_toggleClr[1] together with i_hostAck for ep1 -> toggle[1]=0; i_rst asserted in LOAD -> IDLE next cycle with all outputs 0.
